cgra_cmem_loader: RTL and testbench
===================================

CGRA_CMEM_LOADER -- requirements
Module: cgra_cmem_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of read-data buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter LEN_WIDTH, default 16, meaning the width of the word-count field.
REQ-003 SHALL have port clk_i, input, 1, system clock; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1, single-cycle start pulse.
REQ-006 SHALL have port src_addr_i, input, 32, byte address of the bitstream in system memory; word-aligned.
REQ-007 SHALL have port dst_addr_i, input, 32, byte address in the context-memory slave space; word-aligned.
REQ-008 SHALL have port len_i, input, LEN_WIDTH, number of 32-bit words to copy.
REQ-009 SHALL have port busy_o, output, 1, high while a transfer is in progress.
REQ-010 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port cycles_o, output, 32, transfer cycle count (see Configuration).
REQ-012 SHALL have ports mem_req_o (obi_req_t, output) and mem_resp_i (obi_resp_t, input), the read master to system memory.
REQ-013 SHALL have ports cm_req_o (obi_req_t, output) and cm_resp_i (obi_resp_t, input), the write master driving the CGRA context-memory slave.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-015 Transitions:
  - IDLE->RUN on start_i with len_i!=0.
  - IDLE->DONE on start_i with len_i==0; no bus activity occurs.
  - RUN->DRAIN when the last write is granted.
  - DRAIN->DONE when outstanding writes reach 0.
  - DONE->IDLE unconditionally.
REQ-016 SHALL latch src/dst/len on the accepted start; start_i outside IDLE SHALL be ignored.
REQ-017 busy_o SHALL be high in RUN and DRAIN; done_o SHALL be high only in DONE.
REQ-018 Read i SHALL use addr = src + 4*i, we=0, be=4'hF, wdata=0.
REQ-019 A read SHALL be issued only while reads_issued < len and (reads_outstanding + fifo_count) < FIFO_DEPTH, so the FIFO never overflows.
REQ-020 Once asserted, a req and its addr/we/be/wdata SHALL stay stable until gnt; the issue counters SHALL advance only on req&&gnt.
REQ-021 Each mem rvalid SHALL push rdata into the FIFO in order.
REQ-022 Write j SHALL use addr = dst + 4*j, we=1, be=4'hF, wdata=FIFO head; cm req SHALL be asserted when the FIFO is non-empty and writes_issued < len; the pop SHALL occur on cm gnt.
REQ-023 Simultaneous push and pop in one cycle SHALL keep fifo_count unchanged.
REQ-024 Address arithmetic SHALL be 32-bit modulo (wrap permitted); counters SHALL be LEN_WIDTH+1 bits wide, so len = 2^LEN_WIDTH-1 does not overflow.
REQ-025 Minimum latency SHALL be one cycle from start_i to the first mem req.
REQ-026 SHALL sustain 1 word/cycle when both slaves grant every cycle with 1-cycle rvalid.
REQ-027 cm rvalid SHALL decrement the outstanding-write count; cm rdata SHALL be ignored.
REQ-028 Idle outputs SHALL be: req=0, addr=0, wdata=0, be=0, we=0.

Reset
REQ-029 On rst_ni=0 at a clock edge, the block SHALL take state IDLE, clear all counters and the FIFO, and drive busy_o=0, done_o=0, cycles_o=0, mem_req_o.req=0 and cm_req_o.req=0; the remaining output fields SHALL be 0.
REQ-030 Reset mid-transfer SHALL abandon the transfer without a done pulse; responses that arrive after reset SHALL be ignored.

Configuration
REQ-031 Macro CGRA_CMEM_LOADER_PERF_EN:
  - Defined: a 32-bit counter SHALL clear on the accepted start, increment every cycle in RUN/DRAIN, saturate at 0xFFFFFFFF, and hold its value on cycles_o until the next start.
  - Undefined: cycles_o SHALL be tied to 0 and no counter logic exists.

Structure
REQ-032 The FSM state enum and the FIFO_DEPTH default SHALL live in cgra_pkg; obi_req_t and obi_resp_t SHALL come from obi_pkg.
REQ-033 The buffer SHALL be a sub-module cgra_cmem_loader_fifo (synchronous FIFO with push, pop, full, empty and count, first-word-fall-through).

Verification
REQ-034 Nominal copy: src=0x1000, dst=0x0, len=8, slaves grant every cycle -> 8 writes to cm at 0x0..0x1C carrying the source data in order; done_o pulses once; busy_o stays high throughout.
REQ-035 Zero length: start with len=0 -> done_o=1 on the next cycle, with no mem or cm req ever asserted.
REQ-036 Backpressure: cm gnt held low for 20 cycles, len=16 -> at most FIFO_DEPTH reads are outstanding plus buffered, no data loss, and mem/cm req fields are stable while ungranted.
REQ-037 Reset mid-op: rst_ni=0 after 3 of 10 writes -> all outputs are 0 next cycle; a new start with len=2 then completes correctly.
REQ-038 Start while busy: a second start_i during RUN is ignored and exactly len writes occur.
REQ-039 With PERF_EN, len=4, 1-cycle slaves -> cycles_o equals the measured RUN+DRAIN cycle count; without PERF_EN, cycles_o=0.

Source files
------------

// File: rtl/cgra_pkg.sv
// CGRA shared definitions: loader FSM states, buffer depth default, address helper.
package cgra_pkg;

  localparam int unsigned CMEM_FIFO_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } cmem_state_e;

  // Byte address of 32-bit word idx relative to base, modulo 2^32.
  function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by the context-memory loader slice.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cgra_cmem_loader_if.sv
// One OBI channel (request + response) with master/slave views.
interface cgra_cmem_loader_if;
  import obi_pkg::*;

  obi_req_t  req;
  obi_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/cgra_cmem_loader_fifo.sv
// Synchronous first-word-fall-through FIFO buffering read data for the loader.
module cgra_cmem_loader_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cgra_cmem_loader.sv
// Copies len 32-bit words from system memory (OBI read master) into the CGRA
// context memory (OBI write master) through a small read-data buffer.
// Optional cycle counter on cycles_o: define CGRA_CMEM_LOADER_PERF_EN.
module cgra_cmem_loader
  import cgra_pkg::*;
  import obi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = CMEM_FIFO_DEPTH_DEFAULT,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [31:0]          cycles_o,
  output obi_req_t             mem_req_o,
  input  obi_resp_t            mem_resp_i,
  output obi_req_t             cm_req_o,
  input  obi_resp_t            cm_resp_i
);

  localparam int unsigned FAW = $clog2(FIFO_DEPTH);

  typedef logic [LEN_WIDTH:0] cnt_t;

  cmem_state_e state_q, state_d;
  logic [31:0] src_q, dst_q;
  cnt_t        len_q;
  cnt_t        rd_issued_q, wr_issued_q;
  cnt_t        rd_out_q, wr_out_q;

  logic        start_ok;
  logic        rd_req, wr_req;
  logic        rd_fire, wr_fire;
  logic        rd_rsp, wr_rsp;
  logic        last_wr;

  logic [FAW:0] fifo_count;
  logic         fifo_full;
  logic         fifo_empty;
  logic [31:0]  fifo_head;
  logic         unused_sink;

  assign start_ok = (state_q == IDLE) && start_i;
  assign busy_o   = (state_q == RUN) || (state_q == DRAIN);
  assign done_o   = (state_q == DONE);

  // Issue conditions. Reads in flight plus buffered words never exceed the
  // buffer, and that sum cannot grow while a read waits for its grant, so a
  // raised request stays raised until granted.
  always_comb begin
    rd_req  = (state_q == RUN) && (rd_issued_q < len_q) &&
              ((rd_out_q + cnt_t'(fifo_count)) < cnt_t'(FIFO_DEPTH));
    wr_req  = (state_q == RUN) && !fifo_empty && (wr_issued_q < len_q);
    rd_fire = rd_req && mem_resp_i.gnt;
    wr_fire = wr_req && cm_resp_i.gnt;
    // Responses with nothing outstanding are stale (e.g. from before a reset).
    rd_rsp  = mem_resp_i.rvalid && (rd_out_q != '0);
    wr_rsp  = cm_resp_i.rvalid && (wr_out_q != '0);
    last_wr = wr_fire && ((wr_issued_q + cnt_t'(1)) == len_q);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
      RUN:     if (last_wr) state_d = DRAIN;
      DRAIN:   if (wr_out_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Transfer parameters captured on an accepted start only.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (start_ok) begin
      src_q <= src_addr_i;
      dst_q <= dst_addr_i;
      len_q <= {1'b0, len_i};
    end
  end

  // Issue and outstanding counters; issue counts advance only on req && gnt.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_issued_q <= '0;
      wr_issued_q <= '0;
      rd_out_q    <= '0;
      wr_out_q    <= '0;
    end else begin
      if (start_ok) begin
        rd_issued_q <= '0;
        wr_issued_q <= '0;
      end else begin
        if (rd_fire) rd_issued_q <= rd_issued_q + cnt_t'(1);
        if (wr_fire) wr_issued_q <= wr_issued_q + cnt_t'(1);
      end
      unique case ({rd_fire, rd_rsp})
        2'b10:   rd_out_q <= rd_out_q + cnt_t'(1);
        2'b01:   rd_out_q <= rd_out_q - cnt_t'(1);
        default: rd_out_q <= rd_out_q;
      endcase
      unique case ({wr_fire, wr_rsp})
        2'b10:   wr_out_q <= wr_out_q + cnt_t'(1);
        2'b01:   wr_out_q <= wr_out_q - cnt_t'(1);
        default: wr_out_q <= wr_out_q;
      endcase
    end
  end

  cgra_cmem_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rd_rsp),
    .data_i  (mem_resp_i.rdata),
    .pop_i   (wr_fire),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Bus request drivers; every field reads zero when no request is raised.
  always_comb begin
    mem_req_o = '0;
    cm_req_o  = '0;
    if (rd_req) begin
      mem_req_o.req  = 1'b1;
      mem_req_o.addr = word_addr(src_q, 32'(rd_issued_q));
      mem_req_o.we   = 1'b0;
      mem_req_o.be   = 4'hF;
    end
    if (wr_req) begin
      cm_req_o.req   = 1'b1;
      cm_req_o.addr  = word_addr(dst_q, 32'(wr_issued_q));
      cm_req_o.we    = 1'b1;
      cm_req_o.be    = 4'hF;
      cm_req_o.wdata = fifo_head;
    end
  end

`ifdef CGRA_CMEM_LOADER_PERF_EN
  logic [31:0] cycles_q;

  // Busy-cycle counter: cleared on start, saturating, held after completion.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cycles_q <= '0;
    end else if (start_ok) begin
      cycles_q <= '0;
    end else if (busy_o && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles_o = cycles_q;
`else
  assign cycles_o = '0;
`endif

  // Write-response data carries nothing; the full flag is implied by the issue limit.
  assign unused_sink = ^{fifo_full, cm_resp_i.rdata};

endmodule

// File: tb/tb_cgra_cmem_loader.sv
// Self-checking bench for cgra_cmem_loader: randomised OBI slaves, reference
// copy model (dst+4j <- mem[src+4j]) and directed corner cases.
module tb_cgra_cmem_loader;
  import obi_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   src, dst;
  logic [LW-1:0] len;
  logic          busy, done;
  logic [31:0]   cycles;

  cgra_cmem_loader_if mem_bus ();
  cgra_cmem_loader_if cm_bus ();

  cgra_cmem_loader #(
    .FIFO_DEPTH (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .cycles_o   (cycles),
    .mem_req_o  (mem_bus.req),
    .mem_resp_i (mem_bus.resp),
    .cm_req_o   (cm_bus.req),
    .cm_resp_i  (cm_bus.resp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment-owned observations (written only by the slave process).
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int rd_cnt = 0, wr_cnt = 0, max_inflight = 0;
  int field_err = 0, stab_err = 0, idle_err = 0;
  int busy_cnt = 0, done_cnt = 0, req_cnt = 0;

  // Controls written only by the main sequence.
  int unsigned mem_pct = 100;
  int unsigned cm_pct  = 100;
  time         cm_block_until = 0;

  int last_lat, last_busy;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5EED_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // OBI slaves: observe handshakes at negedge, answer one cycle after grant.
  initial begin
    obi_req_t mem_prev, cm_prev;
    bit mem_wait, cm_wait, mem_pend, cm_pend;
    logic [31:0] mem_pend_data;
    mem_wait = 0; cm_wait = 0; mem_pend = 0; cm_pend = 0;
    mem_pend_data = '0; mem_prev = '0; cm_prev = '0;
    mem_bus.resp = '0;
    cm_bus.resp  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_cnt = 0; wr_cnt = 0; mem_wait = 0; cm_wait = 0;
      end else begin
        if (mem_bus.req.req) begin
          req_cnt++;
          if (mem_bus.req.we !== 1'b0 || mem_bus.req.be !== 4'hF || mem_bus.req.wdata !== '0) field_err++;
          if (mem_wait && mem_bus.req !== mem_prev) stab_err++;
          if (mem_bus.resp.gnt) begin
            rd_addr_q.push_back(mem_bus.req.addr);
            rd_cnt++;
            mem_pend = 1;
            mem_pend_data = mem_word(mem_bus.req.addr);
            mem_wait = 0;
          end else begin
            mem_wait = 1;
            mem_prev = mem_bus.req;
          end
        end else begin
          if (mem_wait) stab_err++;
          mem_wait = 0;
          if (mem_bus.req !== '0) idle_err++;
        end
        if (cm_bus.req.req) begin
          req_cnt++;
          if (cm_bus.req.we !== 1'b1 || cm_bus.req.be !== 4'hF) field_err++;
          if (cm_wait && cm_bus.req !== cm_prev) stab_err++;
          if (cm_bus.resp.gnt) begin
            wr_addr_q.push_back(cm_bus.req.addr);
            wr_data_q.push_back(cm_bus.req.wdata);
            wr_cnt++;
            cm_pend = 1;
            cm_wait = 0;
          end else begin
            cm_wait = 1;
            cm_prev = cm_bus.req;
          end
        end else begin
          if (cm_wait) stab_err++;
          cm_wait = 0;
          if (cm_bus.req !== '0) idle_err++;
        end
        if (rd_cnt - wr_cnt > max_inflight) max_inflight = rd_cnt - wr_cnt;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
      end
      @(posedge clk);
      #1;
      mem_bus.resp.rvalid = mem_pend;
      mem_bus.resp.rdata  = mem_pend ? mem_pend_data : '0;
      mem_pend = 0;
      mem_bus.resp.gnt    = ($urandom_range(99) < mem_pct);
      cm_bus.resp.rvalid  = cm_pend;
      cm_bus.resp.rdata   = $urandom;
      cm_pend = 0;
      cm_bus.resp.gnt     = ($urandom_range(99) < cm_pct) && ($time >= cm_block_until);
    end
  end

  // One transfer against the copy model; dup_at > 0 pulses a second start mid-transfer.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input int dup_at);
    int wb, rb, d0, b0, r0, lat;
    bit got;
    wb = wr_addr_q.size(); rb = rd_addr_q.size();
    d0 = done_cnt; b0 = busy_cnt; r0 = req_cnt;
    @(posedge clk); #1;
    start = 1; src = s; dst = d; len = LW'(n);
    @(posedge clk); #1;
    start = 0; src = $urandom; dst = $urandom; len = LW'($urandom_range(40, 1));
    got = 0; lat = 0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      start = (dup_at > 0) && (c == dup_at);
      if (done) begin
        got = 1;
        lat = c;
      end
    end
    start = 0;
    check("done_seen", 32'(got), 32'd1);
    @(negedge clk);
    @(negedge clk);
    last_lat  = lat;
    last_busy = busy_cnt - b0;
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("wr_count", 32'(wr_addr_q.size() - wb), 32'(n));
    check("rd_count", 32'(rd_addr_q.size() - rb), 32'(n));
    for (int j = 0; j < n; j++) begin
      if (wb + j < wr_addr_q.size()) begin
        check("wr_addr", wr_addr_q[wb+j], d + 32'(4*j));
        check("wr_data", wr_data_q[wb+j], mem_word(s + 32'(4*j)));
      end
      if (rb + j < rd_addr_q.size()) check("rd_addr", rd_addr_q[rb+j], s + 32'(4*j));
    end
    if (n == 0) check("zero_len_no_req", 32'(req_cnt - r0), 32'd0);
  endtask

  initial begin
    int wb, d0;
    bit hit;
    logic [31:0] exp_cyc;
    rst_n = 0; start = 0; src = '0; dst = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_mem_req", 32'(mem_bus.req.req), 32'd0);
    check("rst_cm_req", 32'(cm_bus.req.req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;

    // Nominal copy at full rate: busy for len+4 cycles, done the cycle after.
    run_xfer(32'h0000_1000, 32'h0, 8, 0);
    check("nominal_latency", 32'(last_lat), 32'd12);
    check("nominal_busy", 32'(last_busy), 32'd12);

    // Zero length: done next cycle, no bus activity.
    run_xfer(32'h0000_2000, 32'h0000_0100, 0, 0);
    check("zero_latency", 32'(last_lat), 32'd0);
    check("zero_busy", 32'(last_busy), 32'd0);

    // Performance counter over a len=4 full-rate transfer.
    run_xfer(32'h0000_3000, 32'h0000_0200, 4, 0);
    check("perf_busy", 32'(last_busy), 32'd8);
`ifdef CGRA_CMEM_LOADER_PERF_EN
    exp_cyc = 32'(last_busy);
`else
    exp_cyc = 32'd0;
`endif
    check("perf_cycles", cycles, exp_cyc);

    // Backpressure: context memory refuses grants for 20 cycles.
    cm_block_until = $time + 200;
    run_xfer(32'h0000_4000, 32'h0000_0400, 16, 0);
    check("bp_max_inflight", 32'(max_inflight), 32'(DEPTH));

    // Second start while running is ignored.
    run_xfer(32'h0000_5000, 32'h0000_0800, 6, 3);

    // Address wrap-around.
    run_xfer(32'hFFFF_FFF0, 32'hFFFF_FFF8, 8, 0);

    // Reset after a few writes of a 10-word copy abandons it.
    wb = wr_addr_q.size(); d0 = done_cnt;
    @(posedge clk); #1;
    start = 1; src = 32'h0000_6000; dst = 32'h0000_0C00; len = LW'(10);
    @(posedge clk); #1;
    start = 0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (wr_addr_q.size() - wb >= 3) hit = 1;
    end
    check("mid_reached_3_writes", 32'(hit), 32'd1);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_cycles", cycles, 32'd0);
    check("mid_rst_mem_req", 32'(mem_bus.req.req), 32'd0);
    check("mid_rst_mem_addr", mem_bus.req.addr, 32'd0);
    check("mid_rst_cm_req", 32'(cm_bus.req.req), 32'd0);
    check("mid_rst_cm_addr", cm_bus.req.addr, 32'd0);
    check("mid_rst_cm_wdata", cm_bus.req.wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_abandoned", 32'(wr_addr_q.size() - wb < 10), 32'd1);
    run_xfer(32'h0000_7000, 32'h0000_0E00, 2, 0);

    // Randomised transfers with random grant rates.
    for (int t = 0; t < 8; t++) begin
      mem_pct = $urandom_range(100, 30);
      cm_pct  = $urandom_range(100, 30);
      run_xfer($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, int'($urandom_range(24, 1)), 0);
    end

    check("max_inflight_final", 32'(max_inflight), 32'(DEPTH));
    check("req_stable", 32'(stab_err), 32'd0);
    check("req_fields", 32'(field_err), 32'd0);
    check("idle_fields_zero", 32'(idle_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
